uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer between the UART core (data_rx/rcv) and the UART peripheral read path.
//  - Captures each received byte on the rising edge of rcv.
//  - Holds up to DEPTH bytes, so the processor can poll slower than the line rate without losing data.
//  - Reports empty/full/count status and a sticky overflow flag for the peripheral's status register.
// PARAMETERS
//  DW     8  data width in bits; equals the UART byte width.
//  DEPTH  8  number of FIFO entries; must be a power of two and >= 2.
//  AW     3  pointer width; equals log2(DEPTH).
// PORTS
//  clk       in   1     system clock; all flops update on posedge.
//  rstn      in   1     reset: asynchronous assert, active-low.
//  rcv       in   1     UART core "byte received" level; a byte is valid on data_rx while rcv is high.
//  data_rx   in   DW    received byte from the UART core.
//  rd_en     in   1     pop request: a one-cycle pulse from the peripheral address decode (cs && rd).
//  clr_ovf   in   1     clears the sticky overflow flag.
//  d_out     out  DW    popped byte, registered.
//  empty     out  1     high when count == 0.
//  full      out  1     high when count == DEPTH.
//  count     out  AW+1  number of stored entries, 0..DEPTH.
//  overflow  out  1     sticky flag: a byte was dropped because the FIFO was full.
// BEHAVIOUR
//  Reset (rstn=0, asynchronous):
//   - wr_ptr=0, rd_ptr=0, count=0, rcv_q=0.
//   - d_out=0, empty=1, full=0, overflow=0.
//   - Memory contents are don't-care.
//  Push:
//   - rcv_q is a registered copy of rcv; push = rcv & ~rcv_q.
//   - Exactly one push per rcv high period, however long rcv stays high.
//   - data_rx is sampled in the same cycle push is high.
//  Pop:
//   - pop = rd_en & ~empty.
//   - d_out <= mem[rd_ptr] on the same clock edge, so the value is valid in the cycle after rd_en.
//   - d_out holds its value when there is no pop.
//  Pointers: wr_ptr and rd_ptr are AW bits wide and wrap from DEPTH-1 to 0 naturally; there is no extra wrap bit.
//  Count: count += push_ok - pop. empty and full are derived combinationally from count.
//  Boundary cases:
//   - Push while full, no pop: the byte is dropped, pointers and count are unchanged, overflow <= 1.
//   - Push and pop while full: both are performed, count stays DEPTH, no overflow.
//   - Push and pop while empty: the pop is ignored (no bypass), the push is accepted, count -> 1, d_out holds.
//   - rd_en while empty: ignored, d_out holds. There is no underflow flag.
//   - clr_ovf and a new overflow in the same cycle: overflow stays 1 (set wins).
//   - rcv already high when rstn deasserts: rcv_q=0 produces one push on the first cycle; this is accepted.
//   - rstn asserted mid-stream: all state returns to reset values immediately and buffered bytes are lost.
//  Status outputs reflect the state after the latest clock edge, with no extra latency.
// STRUCTURE
//  Shared package uart_pkg:
//   - UART_DW = 8.
//   - Peripheral address constants: ADDR_TX_DATA=4'h0, ADDR_TX_START=4'h2, ADDR_TX_READY=4'h4,
//     ADDR_RX_STATUS=4'h6, ADDR_RX_DATA=4'h8.
//   - New constant ADDR_RX_COUNT=4'hA.
//  Sub-module fifo_mem_dp: DEPTH x DW register array with one synchronous write port and one synchronous read port.
//  Edge detect, pointers, count and flags stay inline in uart_rx_fifo.
// TESTING
//  1. Reset, then 3 rcv pulses with bytes 0x41, 0x42, 0x43
//     -> count=3, empty=0.
//     Then 3 rd_en pulses -> d_out = 0x41, 0x42, 0x43, each valid one cycle after its rd_en; empty=1 at the end.
//  2. rcv held high for 10 cycles with data_rx=0x55 -> exactly one push, count=1.
//  3. Push 8 bytes 0x00..0x07 -> full=1, count=8.
//     A 9th push of 0xFF -> dropped, overflow=1, count=8.
//     Popping all 8 bytes -> 0x00..0x07 in order; 0xFF never appears on d_out.
//  4. With full=1, push 0xAA and rd_en in the same cycle -> overflow stays 0, count=8.
//     The first popped byte is the oldest entry; 0xAA is popped last.
//  5. Wrap-around: 20 interleaved push/pop pairs with data = index
//     -> data order is preserved, count stays in 0..1, pointers wrap without error.
//  6. With overflow=1: assert clr_ovf alone -> overflow=0.
//     Then clr_ovf together with an overflowing push -> overflow=1.
//     Assert rstn low mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: byte width, peripheral register map and RX FIFO sizing.
package uart_pkg;

  localparam int UART_DW = 8;

  // Peripheral register map (word offsets decoded by the bus front end)
  localparam logic [3:0] ADDR_TX_DATA   = 4'h0;
  localparam logic [3:0] ADDR_TX_START  = 4'h2;
  localparam logic [3:0] ADDR_TX_READY  = 4'h4;
  localparam logic [3:0] ADDR_RX_STATUS = 4'h6;
  localparam logic [3:0] ADDR_RX_DATA   = 4'h8;
  localparam logic [3:0] ADDR_RX_COUNT  = 4'hA;

  // Default receive buffer geometry
  localparam int RX_FIFO_DEPTH = 8;
  localparam int RX_FIFO_AW    = 3;

  // True when n is a power of two and at least 2
  function automatic bit isValidDepth(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART core / peripheral decode and the receive FIFO.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DW = UART_DW,
  parameter int AW = RX_FIFO_AW
) ();

  logic          rcv;
  logic [DW-1:0] data_rx;
  logic          rd_en;
  logic          clr_ovf;
  logic [DW-1:0] d_out;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;

  // Core/peripheral side: supplies bytes and read strobes, observes status
  modport master (
    output rcv, data_rx, rd_en, clr_ovf,
    input  d_out, empty, full, count, overflow
  );

  // FIFO side
  modport slave (
    input  rcv, data_rx, rd_en, clr_ovf,
    output d_out, empty, full, count, overflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// DEPTH x DW register array, one synchronous write port and one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module fifo_mem_dp #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_we,
  input  logic [AW-1:0] i_wrAddr,
  input  logic [DW-1:0] i_wrData,
  input  logic          i_re,
  input  logic [AW-1:0] i_rdAddr,
  output logic [DW-1:0] o_rdData
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdData;

  // Storage array: written only on an accepted push, contents are not reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wrAddr] <= i_wrData;
  end

  // Read register: loads on a pop and otherwise holds the last popped byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     r_rdData <= '0;
    else if (i_re) r_rdData <= r_mem[i_rdAddr];
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: captures one byte per rcv high period, pops on rd_en,
// and reports empty/full/count plus a sticky overflow flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DW    = UART_DW,
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = RX_FIFO_AW
) (
  input  logic          clk,
  input  logic          rstn,
  uart_rx_fifo_if.slave bus
);

  logic          r_rcvQ;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_push;
  logic          w_pushOk;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [DW-1:0] w_rdData;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW + 1)'(DEPTH));
  assign w_push   = bus.rcv & ~r_rcvQ;
  assign w_pop    = bus.rd_en & ~w_empty;
  // A push into a full buffer still fits when a pop frees a slot on the same edge
  assign w_pushOk = w_push & (~w_full | w_pop);

  // Delayed copy of rcv so a long rcv level yields a single push
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_rcvQ <= 1'b0;
    else       r_rcvQ <= bus.rcv;
  end

  // Write and read pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + AW'(1);
    end
  end

  // Occupancy: +1 per accepted push, -1 per pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_count <= '0;
    else       r_count <= r_count + (AW + 1)'(w_pushOk) - (AW + 1)'(w_pop);
  end

  // Sticky overflow: set on a dropped byte, set takes priority over clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         r_overflow <= 1'b0;
    else if (w_push && !w_pushOk)      r_overflow <= 1'b1;
    else if (bus.clr_ovf)              r_overflow <= 1'b0;
  end

  fifo_mem_dp #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .rstn     (rstn),
    .i_we     (w_pushOk),
    .i_wrAddr (r_wrPtr),
    .i_wrData (bus.data_rx),
    .i_re     (w_pop),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_rdData)
  );

  assign bus.d_out    = w_rdData;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int  nChecks = 0;
  int  nFails  = 0;
  bit  checkEn = 1'b0;

  uart_rx_fifo_if #(.DW(DW), .AW(AW)) bus ();

  uart_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a byte queue plus the last popped byte and the sticky flag
  logic [DW-1:0] mQ [$];
  logic [DW-1:0] mDout;
  logic          mOvf;
  logic          mRcvPrev;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mQ.delete();
      mDout    = '0;
      mOvf     = 1'b0;
      mRcvPrev = 1'b0;
    end else begin
      bit newByte;
      bit doPop;
      newByte = bus.rcv && !mRcvPrev;
      doPop   = bus.rd_en && (mQ.size() > 0);
      if (bus.clr_ovf) mOvf = 1'b0;
      if (doPop) mDout = mQ.pop_front();
      if (newByte) begin
        if (mQ.size() < DEPTH) mQ.push_back(bus.data_rx);
        else                   mOvf = 1'b1;
      end
      mRcvPrev = bus.rcv;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc d_out",    int'(bus.d_out),    int'(mDout));
      checkOutput("cyc count",    int'(bus.count),    mQ.size());
      checkOutput("cyc empty",    int'(bus.empty),    int'(mQ.size() == 0));
      checkOutput("cyc full",     int'(bus.full),     int'(mQ.size() == DEPTH));
      checkOutput("cyc overflow", int'(bus.overflow), int'(mOvf));
    end
  end

  // Drive one cycle of inputs just after a rising edge
  task automatic applyStimulus(input logic r, input logic [DW-1:0] d,
                               input logic rd, input logic c);
    @(posedge clk);
    #1;
    bus.rcv     = r;
    bus.data_rx = d;
    bus.rd_en   = rd;
    bus.clr_ovf = c;
  endtask

  task automatic pushByte(input logic [DW-1:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0);
    applyStimulus(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic popByte(input string name, input int exp);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput(name, int'(bus.d_out), exp);
  endtask

  initial begin
    bus.rcv = 1'b0; bus.data_rx = '0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    #12;
    checkOutput("reset d_out", int'(bus.d_out), 0);
    checkOutput("reset empty", int'(bus.empty), 1);
    checkOutput("reset full",  int'(bus.full),  0);
    checkOutput("reset count", int'(bus.count), 0);
    checkOutput("reset ovf",   int'(bus.overflow), 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    rstn = 1'b1;
    checkEn = 1'b1;

    // Three bytes in, three out in order
    pushByte(8'h41); pushByte(8'h42); pushByte(8'h43);
    checkOutput("t1 count", int'(bus.count), 3);
    checkOutput("t1 empty", int'(bus.empty), 0);
    popByte("t1 pop0", 8'h41);
    popByte("t1 pop1", 8'h42);
    popByte("t1 pop2", 8'h43);
    checkOutput("t1 empty end", int'(bus.empty), 1);

    // Long rcv level gives exactly one push
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h55, 1'b0, 1'b0);
    checkOutput("t2 count", int'(bus.count), 1);
    popByte("t2 pop", 8'h55);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) pushByte(8'(i));
    checkOutput("t3 full",  int'(bus.full),  1);
    checkOutput("t3 count", int'(bus.count), 8);
    pushByte(8'hFF);
    checkOutput("t3 ovf",        int'(bus.overflow), 1);
    checkOutput("t3 count ovf",  int'(bus.count),    8);
    for (int i = 0; i < 8; i++) popByte("t3 drain", i);
    checkOutput("t3 empty", int'(bus.empty), 1);

    // Clear alone
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t6 clr", int'(bus.overflow), 0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) pushByte(8'(8'h10 + i));
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'hAA, 1'b0, 1'b0);
    checkOutput("t4 ovf",   int'(bus.overflow), 0);
    checkOutput("t4 count", int'(bus.count),    8);
    checkOutput("t4 first", int'(bus.d_out),    8'h10);
    for (int i = 1; i < 8; i++) popByte("t4 drain", 8'h10 + i);
    popByte("t4 last", 8'hAA);

    // Interleaved push/pop across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'(i), 1'b1, 1'b0);
      checkOutput("t5 count le1", int'(bus.count <= 1), 1);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("t5 data", int'(bus.d_out), i);
    end

    // Clear together with an overflowing push: set wins
    for (int i = 0; i < 8; i++) pushByte(8'(8'h20 + i));
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
    checkOutput("t6 set wins", int'(bus.overflow), 1);

    // Asynchronous reset mid-stream, rcv held high across release
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t6 arst count", int'(bus.count),    0);
    checkOutput("t6 arst empty", int'(bus.empty),    1);
    checkOutput("t6 arst full",  int'(bus.full),     0);
    checkOutput("t6 arst ovf",   int'(bus.overflow), 0);
    checkOutput("t6 arst dout",  int'(bus.d_out),    0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    rstn = 1'b1;
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h33, 1'b0, 1'b0);
    checkOutput("t6 rcv at release", int'(bus.count), 1);
    popByte("t6 rcv byte", 8'h33);

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    nFails++;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
